// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scanner: digit geometry, off levels
// and the active-low hex glyphs ({G,F,E,D,C,B,A}).
package seg7_pkg;

  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned DIGIT_W    = 4;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [7:0] AN_OFF  = 8'hFF;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_e;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment glyph decoder.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [DIGIT_W-1:0] hex_i,
  output logic [6:0]         seg_o
);

  always_comb begin
    seg_o = SEG_OFF;
    case (hex_i)
      4'h0: seg_o = SEG_0;
      4'h1: seg_o = SEG_1;
      4'h2: seg_o = SEG_2;
      4'h3: seg_o = SEG_3;
      4'h4: seg_o = SEG_4;
      4'h5: seg_o = SEG_5;
      4'h6: seg_o = SEG_6;
      4'h7: seg_o = SEG_7;
      4'h8: seg_o = SEG_8;
      4'h9: seg_o = SEG_9;
      4'hA: seg_o = SEG_A;
      4'hB: seg_o = SEG_B;
      4'hC: seg_o = SEG_C;
      4'hD: seg_o = SEG_D;
      4'hE: seg_o = SEG_E;
      4'hF: seg_o = SEG_F;
      default: seg_o = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed 8-digit common-anode display driver with per-digit masking
// and a dark interval at the start of every digit slot to suppress ghosting.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] NUMB,
  input  logic [7:0]  MASK,
  output logic [7:0]  AN,
  output logic [6:0]  SEG,
  output logic        DP
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  // With no blank interval the slot opens directly in SHOW, even out of reset.
  localparam scan_state_e RST_STATE = (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  scan_state_e      state_q, state_d;
  logic [7:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic [6:0]       glyph;
  logic             slot_end;

  assign slot_end = (cnt_q == CNT_LAST);

  hex_to_seg7 u_dec (
    .hex_i (NUMB[DIGIT_W*idx_q +: DIGIT_W]),
    .seg_o (glyph)
  );

  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    state_d = state_q;
    if (slot_end) begin
      cnt_d = '0;
      idx_d = idx_q + 1'b1;
    end
    case (state_q)
      ST_BLANK: if (32'(cnt_d) >= BLANK_CYCLES) state_d = ST_SHOW;
      ST_SHOW:  if (slot_end && BLANK_CYCLES != 0) state_d = ST_BLANK;
      default:  state_d = RST_STATE;
    endcase
  end

  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    if (state_q == ST_SHOW && !MASK[idx_q]) begin
      an_d  = ~(8'b1 << idx_q);
      seg_d = glyph;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      state_q <= RST_STATE;
      an_q    <= AN_OFF;
      seg_q   <= SEG_OFF;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      state_q <= state_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign AN  = an_q;
  assign SEG = seg_q;
  assign DP  = 1'b1;

endmodule

// File: tb/tb_seg7_scan.sv
// Randomized and directed bench for seg7_scan against a slot-timing model.
module tb_seg7_scan;

  localparam int R = 8;
  localparam int B = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] NUMB;
  logic [7:0]  MASK;
  logic [7:0]  AN;
  logic [6:0]  SEG;
  logic        DP;

  int n_tests = 0;
  int n_fail  = 0;
  int c       = 0;  // non-reset edges since the last reset edge

  logic [6:0] dec [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  seg7_scan #(.REFRESH_DIV(R), .BLANK_CYCLES(B)) dut (
    .clk   (clk),
    .reset (reset),
    .NUMB  (NUMB),
    .MASK  (MASK),
    .AN    (AN),
    .SEG   (SEG),
    .DP    (DP)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock: predict from the inputs present before the edge, then compare.
  task automatic step();
    logic [7:0] ean;
    logic [6:0] eseg;
    int cn, ix;
    ean  = 8'hFF;
    eseg = 7'h7F;
    if (reset) begin
      c = 0;
    end else begin
      cn = c % R;
      ix = (c / R) % 8;
      if (cn >= B && !MASK[ix]) begin
        ean  = ~(8'd1 << ix);
        eseg = dec[NUMB[4*ix +: 4]];
      end
      c++;
    end
    @(posedge clk);
    #1;
    check("AN", AN, ean);
    check("SEG", SEG, eseg);
    check("DP", DP, 1'b1);
    check("AN_onehot", ($countones(~AN) <= 1), 1'b1);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) step();
    reset = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int first;
    reset = 1'b1;
    NUMB  = $urandom;
    MASK  = 8'($urandom);
    @(posedge clk);
    #1;

    // Reset with arbitrary inputs, then time the first lit anode.
    do_reset(2);
    check("rst_AN", AN, 8'hFF);
    check("rst_SEG", SEG, 7'h7F);
    MASK  = 8'($urandom) & 8'hFE;
    NUMB  = $urandom;
    first = -1;
    for (int k = 1; k <= 50; k++) begin
      step();
      if (AN != 8'hFF) begin
        first = k;
        break;
      end
    end
    check("first_lit", first, B + 1);

    // Everything masked for three frames.
    MASK = 8'hFF;
    NUMB = 32'hFFFF_FFFF;
    do_reset(1);
    run(3 * 8 * R);

    // Only digit 0 visible.
    MASK = 8'hFE;
    NUMB = 32'h0000_0001;
    do_reset(1);
    run(2 * 8 * R);

    // Full frame of distinct glyphs.
    MASK = 8'h00;
    NUMB = 32'h89AB_CDEF;
    do_reset(1);
    run(8 * R + 1);

    // Live update of MASK, then of NUMB, inside slot 0 SHOW.
    MASK = 8'hFE;
    NUMB = 32'h0000_0001;
    do_reset(1);
    run(B + 3);
    check("live_pre_AN", AN, 8'hFE);
    MASK = 8'hFF;
    step();
    check("live_mask", AN, 8'hFF);
    MASK = 8'hFE;
    step();
    NUMB = 32'h0000_0007;
    step();
    check("live_numb", SEG, 7'b1111000);

    // Reset pulse during slot 5 SHOW, then a clean frame.
    MASK = 8'h00;
    NUMB = 32'h89AB_CDEF;
    do_reset(1);
    run(5 * R + B + 2);
    check("mid_pre_AN", AN, 8'hDF);
    do_reset(1);
    check("mid_rst_AN", AN, 8'hFF);
    run(8 * R + 1);

    // Random inputs with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) MASK = 8'($urandom);
      if ($urandom_range(7) == 0) NUMB = $urandom;
      reset = ($urandom_range(199) == 0);
      step();
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
